// File: rtl/register_arbiter.sv
// register_arbiter: two-requester round-robin access arbiter for a shared register
module register_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Req0_i,
    input  logic             Req1_i,
    input  logic             RW0_i,
    input  logic             RW1_i,
    input  logic [WIDTH-1:0] Data0_i,
    input  logic [WIDTH-1:0] Data1_i,
    output logic             Gnt0_o,
    output logic             Gnt1_o,
    output logic             Ack0_o,
    output logic             Ack1_o,
    output logic [WIDTH-1:0] RdData_o,
    output logic             RegE_o,
    output logic             RegRW_o,
    output logic [WIDTH-1:0] RegDataIn_o,
    input  logic [WIDTH-1:0] RegDataOut_i,
    output logic [7:0]       AccessCount_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t           state_q;
    logic             owner_q, last_q, rw_q;
    logic             gnt0_q, gnt1_q, ack0_q, ack1_q, rege_q, regrw_q;
    logic [WIDTH-1:0] din_q, rd_q;
    logic [7:0]       cnt_q;
    logic             owner_d, rw_d;
    logic [WIDTH-1:0] data_d;
    // Owner choice: the lone requester, or on a tie the one not served last
    always_comb begin
        owner_d = (Req0_i & Req1_i) ? ~last_q : Req1_i;
        rw_d    = owner_d ? RW1_i : RW0_i;
        data_d  = owner_d ? Data1_i : Data0_i;
    end
    // Arbitration FSM with registered grant/enable/ack outputs
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rw_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rege_q  <= 1'b0;
            regrw_q <= 1'b0;
            din_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rege_q  <= 1'b0;
            regrw_q <= 1'b0;
            din_q   <= '0;
            case (state_q)
                IDLE: if (Req0_i | Req1_i) begin
                    state_q <= ACCESS;
                    owner_q <= owner_d;
                    rw_q    <= rw_d;
                    gnt0_q  <= ~owner_d;
                    gnt1_q  <= owner_d;
                    rege_q  <= 1'b1;
                    regrw_q <= rw_d;
                    din_q   <= data_d;
                end
                ACCESS: begin
                    state_q <= DONE;
                    ack0_q  <= ~owner_q;
                    ack1_q  <= owner_q;
                    last_q  <= owner_q;
                    cnt_q   <= cnt_q + 8'd1;
                end
                DONE: begin
                    state_q <= IDLE;
                    if (!rw_q) rd_q <= RegDataOut_i;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Reset blocks any register access combinationally, even mid-ACCESS
    assign RegE_o        = rege_q & ~Reset_i;
    assign RegDataIn_o   = RegE_o ? din_q : '0;
    assign RegRW_o       = regrw_q;
    assign Gnt0_o        = gnt0_q;
    assign Gnt1_o        = gnt1_q;
    assign Ack0_o        = ack0_q;
    assign Ack1_o        = ack1_q;
    assign RdData_o      = rd_q;
    assign AccessCount_o = cnt_q;
endmodule

// File: tb/tb_register_arbiter.sv
// tb_register_arbiter: scoreboard bench for register_arbiter with a shared-register model
module tb_register_arbiter;
    logic        clk = 0, rst = 1;
    logic        req0 = 0, req1 = 0, rw0 = 0, rw1 = 0;
    logic [63:0] data0 = 0, data1 = 0;
    logic        gnt0, gnt1, ack0, ack1, rege, regrw;
    logic [63:0] rddata, regdin, mem = 0;
    logic [7:0]  acnt;

    typedef struct {
        logic        who;
        logic        rw;
        logic [63:0] data;
        logic [63:0] rd;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        acc_q[$];
    exp_t        ack_q[$];
    int          checks = 0, errors = 0, acks_seen = 0, cyc = 0;
    logic [63:0] exp_mem = 0, exp_rd = 0;
    logic [7:0]  exp_cnt = 0;
    logic        gap_chk = 0;

    register_arbiter #(.WIDTH(64)) dut (
        .Clk_i(clk), .Reset_i(rst),
        .Req0_i(req0), .Req1_i(req1), .RW0_i(rw0), .RW1_i(rw1),
        .Data0_i(data0), .Data1_i(data1),
        .Gnt0_o(gnt0), .Gnt1_o(gnt1), .Ack0_o(ack0), .Ack1_o(ack1),
        .RdData_o(rddata), .RegE_o(rege), .RegRW_o(regrw),
        .RegDataIn_o(regdin), .RegDataOut_i(mem), .AccessCount_o(acnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rege && regrw) mem <= regdin;

    // expected outcome of one transaction, computed from the bench's own register model
    task automatic push(input logic who, input logic rw, input logic [63:0] data);
        exp_t e;
        if (rw) exp_mem = data; else exp_rd = exp_mem;
        exp_cnt = exp_cnt + 8'd1;
        e.who = who; e.rw = rw; e.data = data; e.rd = exp_rd; e.cnt = exp_cnt;
        acc_q.push_back(e);
        ack_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n = 0;
        while (acks_seen < target && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check("ack_timeout", 128'(acks_seen), 128'(target));
    endtask

    task automatic do_reset();
        rst = 1; req0 = 0; req1 = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        exp_cnt = 0; exp_rd = 0;
        check("reset_outputs", {gnt0, gnt1, ack0, ack1, rege, regrw, regdin, rddata, acnt},
              '0);
    endtask

    // access-phase monitor: the enabled register access must match the owner's request
    initial begin : acc_mon
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL gnt_exclusive gnt0=%0d gnt1=%0d", gnt0, gnt1);
            end
            if (rege) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_access rw=%0d din=%0h", regrw, regdin);
                end else begin
                    e = acc_q.pop_front();
                    if ({gnt0, gnt1, regrw, regdin} !== {~e.who, e.who, e.rw, e.data}) begin
                        errors++;
                        $display("FAIL access got gnt=%b%b rw=%0d din=%0h want gnt=%b%b rw=%0d din=%0h",
                                 gnt0, gnt1, regrw, regdin, ~e.who, e.who, e.rw, e.data);
                    end
                end
            end
        end
    end

    // completion monitor: ack owner, count, ack spacing and the read result
    initial begin : ack_mon
        exp_t e;
        int   prev = 0;
        bit   have_prev = 0;
        forever begin
            @(negedge clk);
            if (ack0 | ack1) begin
                checks++;
                if (ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack ack0=%0d ack1=%0d", ack0, ack1);
                end else begin
                    e = ack_q.pop_front();
                    acks_seen++;
                    if ({ack0, ack1, acnt} !== {~e.who, e.who, e.cnt}) begin
                        errors++;
                        $display("FAIL ack got ack=%b%b cnt=%0d want ack=%b%b cnt=%0d",
                                 ack0, ack1, acnt, ~e.who, e.who, e.cnt);
                    end
                    if (gap_chk) begin
                        if (have_prev) check("ack_gap", 128'(cyc - prev), 128'd3);
                        have_prev = 1; prev = cyc;
                    end else have_prev = 0;
                    @(posedge clk); #1;
                    check("rd_data", 128'(rddata), 128'(e.rd));
                end
            end
        end
    end

    initial begin
        do_reset();
        // write 75 then read it back through requester 0
        push(0, 1, 64'd75);
        req0 = 1; rw0 = 1; data0 = 64'd75;
        wait_acks(1, 10);
        req0 = 0;
        push(0, 0, 64'd75);
        req0 = 1; rw0 = 0;
        wait_acks(2, 10);
        req0 = 0;
        check("rd_after_read", 128'(rddata), 128'd75);
        check("count_two", 128'(acnt), 128'd2);
        // both requesters held for six transactions: 0 wins first, then alternation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(0, 1, 64'hA5A5);
            push(1, 0, 64'h77);
        end
        gap_chk = 1;
        req0 = 1; rw0 = 1; data0 = 64'hA5A5;
        req1 = 1; rw1 = 0; data1 = 64'h77;
        wait_acks(8, 30);
        req0 = 0; req1 = 0; gap_chk = 0;
        // requester 0 reads while requester 1 (not requesting) toggles its RW and data
        push(0, 0, 64'h1234);
        req0 = 1; rw0 = 0; data0 = 64'h1234;
        for (int i = 0; i < 12 && acks_seen < 9; i++) begin
            @(posedge clk); #1;
            rw1 = ~rw1; data1 = ~data1;
        end
        check("toggle_ack", 128'(acks_seen), 128'd9);
        req0 = 0; rw1 = 0;
        check("toggle_rd", 128'(rddata), 128'hA5A5);
        // requester 1 drops its request once latched; the write still completes
        push(1, 1, 64'hBEEF);
        req1 = 1; rw1 = 1; data1 = 64'hBEEF;
        @(posedge clk); #1;
        req1 = 0;
        wait_acks(10, 10);
        check("mem_after_drop", 128'(mem), 128'(exp_mem));
        // reset lands during the ACCESS cycle of a write of 0xFFFF
        req1 = 1; rw1 = 1; data1 = 64'hFFFF;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("reset_mid_rege", {rege, regdin}, '0);
        @(posedge clk); #1;
        rst = 0; req1 = 0;
        exp_cnt = 0; exp_rd = 0;
        check("reset_mid_outputs", {ack0, ack1, rege, rddata, acnt}, '0);
        repeat (4) @(posedge clk);
        #1;
        check("reset_mid_count", {acnt, rddata}, '0);
        check("reset_mid_mem", 128'(mem), 128'(exp_mem));
        // 256 back-to-back writes wrap AccessCount to 0, then one more read
        do_reset();
        for (int i = 0; i < 256; i++) push(0, 1, 64'h5A);
        req0 = 1; rw0 = 1; data0 = 64'h5A;
        wait_acks(266, 1000);
        req0 = 0;
        check("count_wrap", 128'(acnt), 128'd0);
        push(1, 0, 64'h3);
        req1 = 1; rw1 = 0; data1 = 64'h3;
        wait_acks(267, 10);
        req1 = 0;
        check("count_after_wrap", 128'(acnt), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        check("acc_q_drained", 128'(acc_q.size()), 128'd0);
        check("ack_q_drained", 128'(ack_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_arbiter.md
REGISTER_ARBITER -- requirements
Module: register_arbiter

Interface
REQ-001 Parameter: WIDTH, default 64, data width of the shared register and all data ports.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 Req0, Req1  input  1 each  access request from requester 0 and requester 1.
REQ-005 RW0, RW1  input  1 each  request type per requester: 1 = write, 0 = read.
REQ-006 Data0, Data1  input  WIDTH each  write data per requester.
REQ-007 Gnt0, Gnt1  output  1 each  requester currently owns the register (ACCESS state).
REQ-008 Ack0, Ack1  output  1 each  one-cycle completion pulse per requester.
REQ-009 RdData  output  WIDTH  last read result, registered.
REQ-010 RegE, RegRW, RegDataIn  output  1/1/WIDTH  enable, read/write select and write data to the shared 64-bit register.
REQ-011 RegDataOut  input  WIDTH  data returned by the shared register.
REQ-012 AccessCount  output  8  completed transactions, both requesters combined.

Function
REQ-013 FSM SHALL have exactly three states, IDLE, ACCESS and DONE, plus a 1-bit priority pointer Last (requester most recently served).
REQ-014 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-015 In IDLE with any Reqx high, the FSM SHALL go to ACCESS and latch the owner, selected as follows:
- only one requester active: that requester;
- both active: the requester not equal to Last (round robin).
REQ-016 ACCESS SHALL last exactly one cycle and then go to DONE; DONE SHALL last exactly one cycle and then go to IDLE.
REQ-017 In ACCESS, the outputs SHALL be:
- RegE = 1 and Gntx = 1 for the owner only;
- RegRW = owner's RWx, RegDataIn = owner's Datax;
- RegE and Gnt0/Gnt1 = 0 in every other state.
REQ-018 In DONE, the block SHALL:
- pulse Ackx = 1 for the owner for exactly one cycle;
- set Last = owner;
- increment AccessCount by 1, wrapping 255 -> 0.
REQ-019 For a read (RW = 0), RdData SHALL load RegDataOut at the edge leaving DONE and hold it until the next read completes; writes leave RdData unchanged.
REQ-020 RegDataIn SHALL be 0 when RegE = 0.
REQ-021 Latency: request seen in IDLE at edge n -> RegE high during cycle n+1 -> Ack high during cycle n+2 -> IDLE during cycle n+3; throughput is one transaction per 3 cycles.
REQ-022 Requester contract: Reqx, RWx and Datax stay stable until Ackx is seen, and Reqx drops in the cycle after Ackx; a Reqx still high in IDLE is a new request.
REQ-023 Changes to the non-owner's Req, RW or Data during ACCESS or DONE SHALL have no effect on the current transaction.
REQ-024 A requester that drops Reqx before its Ack SHALL still have its transaction completed once it has been latched as owner.

Reset
REQ-025 With Reset high at a rising edge, the block SHALL go to IDLE, set Last = 1 (requester 0 wins the first tie), and set Gnt0/Gnt1, Ack0/Ack1, RegE, RegRW, RegDataIn, RdData and AccessCount to 0.
REQ-026 RegE SHALL be gated with ~Reset so no register access is issued in any cycle where Reset is high, including mid-ACCESS.
REQ-027 A transaction interrupted by Reset SHALL produce no Ack and no AccessCount increment.

Verification
REQ-028 Write then read:
- stimulus: Req0 = 1, RW0 = 1, Data0 = 75;
- response: RegE = 1, RegRW = 1, RegDataIn = 75 for one cycle; Ack0 one cycle later;
- then Req0 read: RdData = 75 after Ack0, AccessCount = 2.
REQ-029 Simultaneous Req0 and Req1 after reset:
- requester 0 is granted first, then requester 1 on the next IDLE;
- Ack0 and Ack1 are 3 cycles apart; Gnt0 and Gnt1 are never high together.
REQ-030 Both requests held continuously for 6 transactions: grants alternate 0,1,0,1,0,1.
REQ-031 Reset asserted during ACCESS of a write with Data1 = 0xFFFF:
- RegE is 0 that cycle;
- no Ack1;
- after reset, AccessCount = 0 and RdData = 0.
REQ-032 AccessCount wrap: after 256 completed transactions, AccessCount = 0 and Acks continue normally.
REQ-033 Read while the non-owner toggles Data1 and RW1 in ACCESS: RdData equals the register content, and RegDataIn and RegRW follow the owner only.
